// File: rtl/pacman_pkg.sv
// pacman_pkg: screen/map geometry, tile codes and probe bookkeeping types for the tile probe.
// CORNER_PROBE_EN selects four corner probes per enemy instead of the top-left probe only.
package pacman_pkg;
  localparam int SCR_W = 1920;
  localparam int SCR_H = 1080;
  localparam int MAP_W = 48;
  localparam int MAP_H = 27;
  localparam int TILE_W = 40;
  localparam int TILE_H = 40;
  localparam int ENEMY_SIZE = 40;
  localparam logic [3:0] TILE_BG = 4'd0;
  localparam logic [3:0] TILE_WALL = 4'd1;
  localparam logic [3:0] TILE_COIN = 4'd2;
  // 1639/65536 approximates 1/40 closely enough to floor exactly for 0..2047
  localparam int RECIP = 1639;
  localparam int RECIP_SH = 16;
`ifdef CORNER_PROBE_EN
  localparam int PROBES = 16;
`else
  localparam int PROBES = 4;
`endif
  localparam int PW = $clog2(PROBES);
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic v;
    logic [1:0] e;
    logic [1:0] c;
  } rd_tag_t;
endpackage

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: pixel (x,y) to clamped map tile address, one registered stage.
module tile_addr_calc
  import pacman_pkg::*;
(
  input  logic        clk_pix,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic [12:0] x_i,
  input  logic [12:0] y_i,
  output logic [10:0] addr_o
);
  logic [5:0] col;
  logic [4:0] row;
  logic [10:0] addr_d, addr_q;
  always_comb begin
    col = (x_i >= 13'(SCR_W)) ? 6'(MAP_W - 1) : 6'((22'(x_i[10:0]) * 22'(RECIP)) >> RECIP_SH);
    row = (y_i >= 13'(SCR_H)) ? 5'(MAP_H - 1) : 5'((22'(y_i[10:0]) * 22'(RECIP)) >> RECIP_SH);
    addr_d = clr_i ? 11'd0 : 11'(row) * 11'(MAP_W) + 11'(col);
  end
  always_ff @(posedge clk_pix or negedge rstn)
    if (!rstn) addr_q <= '0;
    else addr_q <= addr_d;
  assign addr_o = addr_q;
endmodule

// File: rtl/enemy_tile_probe.sv
// enemy_tile_probe: per-frame snapshot of four enemies, map probes through one read port,
// atomic commit of tile address/code. CORNER_PROBE_EN enables four-corner wall probing.
module enemy_tile_probe
  import pacman_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk_pix,
  input  logic        rstn,
  input  logic        frame_tick,
  input  logic        game_reset,
  input  logic [11:0] enemy0_x, enemy0_y, enemy1_x, enemy1_y,
  input  logic [11:0] enemy2_x, enemy2_y, enemy3_x, enemy3_y,
  output logic        map_rd_en,
  output logic [10:0] map_addr,
  input  logic [3:0]  map_data,
  output logic [10:0] tile0_addr, tile1_addr, tile2_addr, tile3_addr,
  output logic [3:0]  tile0_code, tile1_code, tile2_code, tile3_code,
  output logic        scan_done,
  output logic        scan_overrun
);
  state_t state_q, state_d;
  logic [PW-1:0] k_q, k_d, f;
  logic [1:0] dcnt_q, dcnt_d, pe, pc, fe, fc;
  logic [11:0] ex [4], ey [4], sx_q [4], sx_d [4], sy_q [4], sy_d [4];
  logic [10:0] pa_q [4], pa_d [4], ta_q [4], ta_d [4], calc_addr;
  logic [3:0] pt_q [4], pt_d [4], tc_q [4], tc_d [4];
  logic [3:0] pw_q, pw_d;
  logic [12:0] fx, fy;
  rd_tag_t tag_q [RD_LAT], tag_d [RD_LAT], ret;
  assign ex = '{enemy0_x, enemy1_x, enemy2_x, enemy3_x};
  assign ey = '{enemy0_y, enemy1_y, enemy2_y, enemy3_y};
  // the address stage is fed one probe ahead of the one being issued
  assign f = (state_q == S_SNAP) ? '0 : k_q + 1'b1;
`ifdef CORNER_PROBE_EN
  assign pe = k_q[3:2];
  assign pc = k_q[1:0];
  assign fe = f[3:2];
  assign fc = f[1:0];
`else
  assign pe = k_q;
  assign pc = 2'd0;
  assign fe = f;
  assign fc = 2'd0;
`endif
  assign fx = 13'(sx_q[fe]) + (fc[0] ? 13'(ENEMY_SIZE - 1) : 13'd0);
  assign fy = 13'(sy_q[fe]) + (fc[1] ? 13'(ENEMY_SIZE - 1) : 13'd0);
  tile_addr_calc u_calc (
    .clk_pix(clk_pix), .rstn(rstn), .clr_i(game_reset), .x_i(fx), .y_i(fy), .addr_o(calc_addr)
  );
  assign ret = tag_q[RD_LAT-1];
  assign map_rd_en = state_q == S_ISSUE;
  assign map_addr = map_rd_en ? calc_addr : 11'd0;
  assign scan_done = state_q == S_DONE;
  assign scan_overrun = frame_tick && state_q != S_IDLE;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    dcnt_d = dcnt_q;
    sx_d = sx_q;
    sy_d = sy_q;
    pa_d = pa_q;
    pt_d = pt_q;
    pw_d = pw_q;
    ta_d = ta_q;
    tc_d = tc_q;
    tag_d[0] = {map_rd_en, pe, pc};
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    case (state_q)
      S_IDLE: if (frame_tick) begin
        state_d = S_SNAP;
        sx_d = ex;
        sy_d = ey;
      end
      S_SNAP: begin
        state_d = S_ISSUE;
        k_d = '0;
        pw_d = '0;
      end
      S_ISSUE: begin
        k_d = k_q + 1'b1;
        if (k_q == PW'(PROBES - 1)) begin
          state_d = S_DRAIN;
          dcnt_d = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == 2'(RD_LAT - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (map_rd_en && pc == 2'd0) pa_d[pe] = map_addr;
    if (ret.v) begin
      if (ret.c == 2'd0) pt_d[ret.e] = map_data;
      if (map_data == TILE_WALL) pw_d[ret.e] = 1'b1;
    end
    // commit on the edge into DONE so the new values are visible alongside scan_done
    if (state_q == S_DRAIN && dcnt_q == 2'(RD_LAT - 1))
      for (int i = 0; i < 4; i++) begin
        ta_d[i] = pa_d[i];
        tc_d[i] = pw_d[i] ? TILE_WALL : pt_d[i];
      end
    if (game_reset) begin
      state_d = S_IDLE;
      k_d = '0;
      dcnt_d = '0;
      sx_d = '{default: '0};
      sy_d = '{default: '0};
      pa_d = '{default: '0};
      pt_d = '{default: '0};
      pw_d = '0;
      ta_d = '{default: '0};
      tc_d = '{default: '0};
      tag_d = '{default: '0};
    end
  end
  always_ff @(posedge clk_pix or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q <= '0;
      dcnt_q <= '0;
      sx_q <= '{default: '0};
      sy_q <= '{default: '0};
      pa_q <= '{default: '0};
      pt_q <= '{default: '0};
      pw_q <= '0;
      ta_q <= '{default: '0};
      tc_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      dcnt_q <= dcnt_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      pa_q <= pa_d;
      pt_q <= pt_d;
      pw_q <= pw_d;
      ta_q <= ta_d;
      tc_q <= tc_d;
      tag_q <= tag_d;
    end
  assign {tile0_addr, tile1_addr, tile2_addr, tile3_addr} = {ta_q[0], ta_q[1], ta_q[2], ta_q[3]};
  assign {tile0_code, tile1_code, tile2_code, tile3_code} = {tc_q[0], tc_q[1], tc_q[2], tc_q[3]};
endmodule

// File: tb/tb_enemy_tile_probe.sv
// tb_enemy_tile_probe: directed tests for enemy_tile_probe with a latency-matched map model.
module tb_enemy_tile_probe;
  import pacman_pkg::*;
  localparam int RD_LAT = 1;
  localparam int DONE_CYC = PROBES + RD_LAT + 2;
`ifdef CORNER_PROBE_EN
  localparam logic [3:0] CORNER_CODE = 4'd1;
`else
  localparam logic [3:0] CORNER_CODE = 4'd0;
`endif
  logic clk_pix = 1'b0, rstn = 1'b0, frame_tick = 1'b0, game_reset = 1'b0;
  logic [11:0] enemy0_x, enemy0_y, enemy1_x, enemy1_y, enemy2_x, enemy2_y, enemy3_x, enemy3_y;
  logic map_rd_en, scan_done, scan_overrun;
  logic [10:0] map_addr, tile0_addr, tile1_addr, tile2_addr, tile3_addr;
  logic [3:0] map_data, tile0_code, tile1_code, tile2_code, tile3_code;
  logic [3:0] mem [2048];
  logic [3:0] pipe [RD_LAT];
  int vectors = 0, miscompares = 0;

  enemy_tile_probe #(.RD_LAT(RD_LAT)) dut (
    .clk_pix(clk_pix), .rstn(rstn), .frame_tick(frame_tick), .game_reset(game_reset),
    .enemy0_x(enemy0_x), .enemy0_y(enemy0_y), .enemy1_x(enemy1_x), .enemy1_y(enemy1_y),
    .enemy2_x(enemy2_x), .enemy2_y(enemy2_y), .enemy3_x(enemy3_x), .enemy3_y(enemy3_y),
    .map_rd_en(map_rd_en), .map_addr(map_addr), .map_data(map_data),
    .tile0_addr(tile0_addr), .tile1_addr(tile1_addr), .tile2_addr(tile2_addr), .tile3_addr(tile3_addr),
    .tile0_code(tile0_code), .tile1_code(tile1_code), .tile2_code(tile2_code), .tile3_code(tile3_code),
    .scan_done(scan_done), .scan_overrun(scan_overrun)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    pipe[0] <= map_rd_en ? mem[map_addr] : 4'd0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign map_data = pipe[RD_LAT-1];

  task automatic clear_map();
    for (int i = 0; i < 2048; i++) mem[i] = 4'd0;
  endtask

  task automatic set_en(input logic [11:0] x0, y0, x1, y1, x2, y2, x3, y3);
    {enemy0_x, enemy0_y, enemy1_x, enemy1_y} = {x0, y0, x1, y1};
    {enemy2_x, enemy2_y, enemy3_x, enemy3_y} = {x2, y2, x3, y3};
  endtask

  task automatic run_scan(output int cyc, output int rd_cyc, output int rd_n,
                          output logic [10:0] rd_addr, output logic [14:0] pre);
    rd_cyc = 0;
    rd_n = 0;
    rd_addr = '0;
    pre = '0;
    @(negedge clk_pix) frame_tick = 1'b1;
    @(negedge clk_pix) frame_tick = 1'b0;
    cyc = 1;
    while (!scan_done && cyc < 100) begin
      if (map_rd_en) begin
        if (rd_n == 0) begin
          rd_cyc = cyc;
          rd_addr = map_addr;
        end
        rd_n++;
      end
      if (cyc == DONE_CYC - 1) pre = {tile0_addr, tile0_code};
      @(negedge clk_pix);
      cyc++;
    end
  endtask

  task automatic test_reset();
    set_en(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    repeat (2) @(negedge clk_pix);
    vectors++;
    if ({map_rd_en, map_addr, scan_done, scan_overrun} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rd_en=%0d addr=%0d done=%0d ovr=%0d want all 0",
               map_rd_en, map_addr, scan_done, scan_overrun);
    end
    vectors++;
    if ({tile0_addr, tile1_addr, tile2_addr, tile3_addr, tile0_code, tile1_code, tile2_code, tile3_code} !== 60'd0) begin
      miscompares++;
      $display("FAIL reset_tiles: got %0d/%0d %0d/%0d %0d/%0d %0d/%0d want all 0", tile0_addr, tile0_code,
               tile1_addr, tile1_code, tile2_addr, tile2_code, tile3_addr, tile3_code);
    end
    rstn = 1'b1;
    @(negedge clk_pix);
  endtask

  task automatic test_basic();
    int cyc, rd_cyc, rd_n;
    logic [10:0] rd_addr;
    logic [14:0] pre;
    clear_map();
    mem[100] = TILE_WALL;
    set_en(160, 80, 0, 0, 0, 0, 0, 0);
    run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
    vectors++;
    if (cyc !== DONE_CYC) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want %0d", cyc, DONE_CYC); end
    vectors++;
    if (rd_cyc !== 2 || rd_addr !== 11'd100) begin
      miscompares++;
      $display("FAIL basic_first_probe: got cycle %0d addr %0d want cycle 2 addr 100", rd_cyc, rd_addr);
    end
    vectors++;
    if (rd_n !== PROBES) begin miscompares++; $display("FAIL basic_probe_count: got %0d want %0d", rd_n, PROBES); end
    vectors++;
    if (pre !== 15'd0) begin miscompares++; $display("FAIL basic_hold_before_done: got %0h want 0", pre); end
    vectors++;
    if (tile0_addr !== 11'd100 || tile0_code !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_tile0: got %0d/%0d want 100/1", tile0_addr, tile0_code);
    end
    vectors++;
    if ({tile1_addr, tile2_addr, tile3_addr, tile1_code, tile2_code, tile3_code} !== 45'd0) begin
      miscompares++;
      $display("FAIL basic_tile123: got %0d/%0d %0d/%0d %0d/%0d want 0/0", tile1_addr, tile1_code,
               tile2_addr, tile2_code, tile3_addr, tile3_code);
    end
    @(negedge clk_pix);
    vectors++;
    if (scan_done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %0d want 0", scan_done); end
  endtask

  task automatic test_boundary();
    int cyc, rd_cyc, rd_n;
    logic [10:0] rd_addr;
    logic [14:0] pre;
    clear_map();
    mem[0] = 4'd3;
    mem[49] = TILE_COIN;
    mem[1295] = TILE_COIN;
    set_en(1919, 1079, 39, 39, 40, 40, 2047, 4095);
    run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
    vectors++;
    if ({tile0_addr, tile1_addr, tile2_addr, tile3_addr} !== {11'd1295, 11'd0, 11'd49, 11'd1295}) begin
      miscompares++;
      $display("FAIL bound_addr: got %0d %0d %0d %0d want 1295 0 49 1295", tile0_addr, tile1_addr, tile2_addr, tile3_addr);
    end
    vectors++;
    if ({tile0_code, tile1_code, tile2_code, tile3_code} !== 16'h2322) begin
      miscompares++;
      $display("FAIL bound_code: got %0d %0d %0d %0d want 2 3 2 2", tile0_code, tile1_code, tile2_code, tile3_code);
    end
    clear_map();
    for (int x = 0; x < SCR_W; x += 4) begin
      set_en(12'(x), 0, 12'(x + 1), 0, 12'(x + 2), 0, 12'(x + 3), 0);
      run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
      vectors++;
      if ({tile0_addr, tile1_addr, tile2_addr, tile3_addr} !==
          {11'(x / 40), 11'((x + 1) / 40), 11'((x + 2) / 40), 11'((x + 3) / 40)}) begin
        miscompares++;
        $display("FAIL sweep_x x=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", x, tile0_addr, tile1_addr,
                 tile2_addr, tile3_addr, x / 40, (x + 1) / 40, (x + 2) / 40, (x + 3) / 40);
      end
    end
    for (int y = 0; y < SCR_H; y += 4) begin
      set_en(0, 12'(y), 0, 12'(y + 1), 0, 12'(y + 2), 0, 12'(y + 3));
      run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
      vectors++;
      if ({tile0_addr, tile1_addr, tile2_addr, tile3_addr} !==
          {11'(y / 40 * 48), 11'((y + 1) / 40 * 48), 11'((y + 2) / 40 * 48), 11'((y + 3) / 40 * 48)}) begin
        miscompares++;
        $display("FAIL sweep_y y=%0d: got %0d %0d %0d %0d", y, tile0_addr, tile1_addr, tile2_addr, tile3_addr);
      end
    end
  endtask

  task automatic test_overrun();
    int ov = 0, dn = 0;
    clear_map();
    mem[100] = TILE_WALL;
    set_en(160, 80, 0, 0, 0, 0, 0, 0);
    @(negedge clk_pix) frame_tick = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_pix);
      frame_tick = (cyc == 3 || cyc == 7);
      if (cyc == 1) set_en(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (scan_overrun) ov++;
      if (scan_done) dn++;
    end
    frame_tick = 1'b0;
    vectors++;
    if (ov !== 2) begin miscompares++; $display("FAIL overrun_count: got %0d want 2", ov); end
    vectors++;
    if (dn !== 1) begin miscompares++; $display("FAIL overrun_done_count: got %0d want 1", dn); end
    vectors++;
    if (tile0_addr !== 11'd100 || tile0_code !== 4'd1) begin
      miscompares++;
      $display("FAIL overrun_snapshot: got %0d/%0d want 100/1", tile0_addr, tile0_code);
    end
  endtask

  task automatic test_game_reset();
    int cyc, rd_cyc, rd_n, dn = 0, act = 0;
    logic [10:0] rd_addr;
    logic [14:0] pre;
    clear_map();
    mem[100] = TILE_WALL;
    set_en(160, 80, 0, 0, 0, 0, 0, 0);
    run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
    @(negedge clk_pix) frame_tick = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_pix);
      frame_tick = 1'b0;
      game_reset = (c == 4);
      if (c == 5) begin
        vectors++;
        if (map_rd_en !== 1'b0) begin miscompares++; $display("FAIL greset_rd_en: got %0d want 0", map_rd_en); end
        vectors++;
        if ({tile0_addr, tile0_code} !== 15'd0) begin
          miscompares++;
          $display("FAIL greset_clear: got %0d/%0d want 0/0", tile0_addr, tile0_code);
        end
      end
      if (scan_done) dn++;
    end
    vectors++;
    if (dn !== 0) begin miscompares++; $display("FAIL greset_no_done: got %0d want 0", dn); end
    @(negedge clk_pix) {frame_tick, game_reset} = 2'b11;
    @(negedge clk_pix) {frame_tick, game_reset} = 2'b00;
    repeat (DONE_CYC + 4) begin
      if (map_rd_en || scan_done) act++;
      @(negedge clk_pix);
    end
    vectors++;
    if (act !== 0) begin miscompares++; $display("FAIL greset_wins: got %0d active cycles want 0", act); end
    run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
    vectors++;
    if (cyc !== DONE_CYC || tile0_addr !== 11'd100 || tile0_code !== 4'd1) begin
      miscompares++;
      $display("FAIL greset_rescan: got cycle %0d tile0 %0d/%0d want %0d 100/1", cyc, tile0_addr, tile0_code, DONE_CYC);
    end
  endtask

  task automatic test_async_reset();
    int dn = 0;
    @(negedge clk_pix) frame_tick = 1'b1;
    @(negedge clk_pix) frame_tick = 1'b0;
    @(negedge clk_pix);
    @(negedge clk_pix);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({map_rd_en, tile0_addr, tile0_code} !== 16'd0) begin
      miscompares++;
      $display("FAIL arst_clear: got rd_en=%0d tile0 %0d/%0d want 0 0/0", map_rd_en, tile0_addr, tile0_code);
    end
    @(negedge clk_pix) rstn = 1'b1;
    repeat (DONE_CYC + 4) begin
      @(negedge clk_pix);
      if (scan_done) dn++;
    end
    vectors++;
    if (dn !== 0) begin miscompares++; $display("FAIL arst_no_done: got %0d want 0", dn); end
  endtask

  task automatic test_corner();
    int cyc, rd_cyc, rd_n;
    logic [10:0] rd_addr;
    logic [14:0] pre;
    clear_map();
    mem[1] = TILE_WALL;
    set_en(20, 0, 0, 0, 0, 0, 0, 0);
    run_scan(cyc, rd_cyc, rd_n, rd_addr, pre);
    vectors++;
    if (cyc !== DONE_CYC) begin miscompares++; $display("FAIL corner_done_cycle: got %0d want %0d", cyc, DONE_CYC); end
    vectors++;
    if (tile0_addr !== 11'd0 || tile0_code !== CORNER_CODE) begin
      miscompares++;
      $display("FAIL corner_tile0: got %0d/%0d want 0/%0d", tile0_addr, tile0_code, CORNER_CODE);
    end
  endtask

  initial begin
    clear_map();
    test_reset();
    test_basic();
    test_boundary();
    test_overrun();
    test_game_reset();
    test_async_reset();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
